// File: rtl/tc_multi.sv
// tc_multi: multi-channel prescaled down-counter timer with shared W1C status and registered irq
// Ports: clk, rst (sync, active-high); addr[5:4] channel, addr[3:2] register
// (0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS); we/din write port; dout combinational
// read data; irq registered OR over channels of pending & IM.
module tc_multi #(
    parameter int NCH = 2,
    parameter int CW  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:2]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);
    localparam logic [15:0] CTRL_MASK = 16'hff0f;
    logic [15:0]    ctrl   [NCH];
    logic [CW-1:0]  preset [NCH];
    logic [CW-1:0]  count  [NCH];
    logic [7:0]     psc    [NCH];
    logic [NCH-1:0] pending, im, wr_ctrl, wr_pre, tick, ev, clr;
    logic           ch_ok;
    assign ch_ok = int'(addr[5:4]) < NCH;
    assign clr   = (we && ch_ok && addr[3:2] == 2'd3) ? din[NCH-1:0] : '0;
    // A CTRL or PRESET write to a channel suppresses its tick that cycle,
    // which is also what makes a colliding PRESET write beat the event.
    always_comb begin
        wr_ctrl = '0;
        wr_pre  = '0;
        tick    = '0;
        ev      = '0;
        im      = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_ctrl[i] = we && addr[5:4] == 2'(i) && addr[3:2] == 2'd0;
            wr_pre[i]  = we && addr[5:4] == 2'(i) && addr[3:2] == 2'd1;
            tick[i]    = ctrl[i][0] && !wr_ctrl[i] && !wr_pre[i] && psc[i] == ctrl[i][15:8];
            ev[i]      = tick[i] && count[i] == '0;
            im[i]      = ctrl[i][3];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                ctrl[i]   <= '0;
                preset[i] <= '0;
                count[i]  <= '0;
                psc[i]    <= '0;
            end
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_ctrl[i]) begin
                    ctrl[i] <= din[15:0] & CTRL_MASK;
                    psc[i]  <= '0;
                end else if (wr_pre[i]) begin
                    preset[i] <= din[CW-1:0];
                    count[i]  <= din[CW-1:0];
                    psc[i]    <= '0;
                end else if (ctrl[i][0]) begin
                    psc[i] <= tick[i] ? 8'd0 : psc[i] + 8'd1;
                    if (tick[i] && count[i] != '0)
                        count[i] <= count[i] - CW'(1);
                    else if (ev[i] && ctrl[i][2:1] == 2'b01)
                        count[i] <= preset[i];
                    else if (ev[i])
                        ctrl[i][0] <= 1'b0;
                end
            end
            // Set beats a simultaneous W1C clear.
            pending <= (pending & ~clr) | ev;
            irq     <= |(pending & im);
        end
    end
    always_comb begin
        dout = '0;
        for (int i = 0; i < NCH; i++)
            if (addr[5:4] == 2'(i))
                dout = addr[3:2] == 2'd0 ? {16'd0, ctrl[i]} :
                       addr[3:2] == 2'd1 ? 32'(preset[i]) :
                       addr[3:2] == 2'd2 ? 32'(count[i]) : 32'(pending);
    end
endmodule
